// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low a..g patterns, reader FSM states,
// and display-side helpers used by both the reader and anything driving a panel.
package seg_pkg;

    // seg[7:1] = segments a..g, active-low
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [3:0] AN_BLANK  = 4'hF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IGNORE   = 2'd0,
        ST_SETTLING = 2'd1,
        ST_HELD     = 2'd2
    } seg_state_t;

    // Exactly one digit enabled (active-low).
    function automatic logic onehot_low(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    // Display side: nibble plus dp to a full active-low segment byte.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib, input logic dp);
        logic [6:0] p;
        case (nib)
            4'h0: p = SEG_0;
            4'h1: p = SEG_1;
            4'h2: p = SEG_2;
            4'h3: p = SEG_3;
            4'h4: p = SEG_4;
            4'h5: p = SEG_5;
            4'h6: p = SEG_6;
            4'h7: p = SEG_7;
            4'h8: p = SEG_8;
            4'h9: p = SEG_9;
            4'hA: p = SEG_A;
            4'hB: p = SEG_B;
            4'hC: p = SEG_C;
            4'hD: p = SEG_D;
            4'hE: p = SEG_E;
            default: p = SEG_F;
        endcase
        return {p, ~dp};
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational segment-pattern to nibble decoder; hit is low for patterns
// that are not one of the sixteen hex glyphs.
module seg_decode
    import seg_pkg::*;
(
    input  logic [7:1] seg,
    output logic [3:0] value,
    output logic       hit
);

    always_comb begin
        value = 4'h0;
        hit   = 1'b1;
        case (seg)
            SEG_0: value = 4'h0;
            SEG_1: value = 4'h1;
            SEG_2: value = 4'h2;
            SEG_3: value = 4'h3;
            SEG_4: value = 4'h4;
            SEG_5: value = 4'h5;
            SEG_6: value = 4'h6;
            SEG_7: value = 4'h7;
            SEG_8: value = 4'h8;
            SEG_9: value = 4'h9;
            SEG_A: value = 4'hA;
            SEG_B: value = 4'hB;
            SEG_C: value = 4'hC;
            SEG_D: value = 4'hD;
            SEG_E: value = 4'hE;
            SEG_F: value = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// Recovers the four hex digits shown on a multiplexed active-low seven-segment
// display by sampling its anode/segment lines and capturing each stable digit.
module seg_reader
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ssd_an,
    input  logic [7:0]  ssd_seg,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic [3:0]  errs,
    output logic        frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [3:0]      s_an;
    logic [7:0]      s_seg;
    logic [CW-1:0]   cnt;
    seg_state_t      state, state_nxt;
    logic            chg, an_ok, cap;
    logic [1:0]      idx;
    logic [3:0]      dval;
    logic            hit;

    logic [3:0][3:0] sh_val, fr_val;
    logic [3:0]      sh_dp, sh_err, fr_dp, fr_err;
    logic [3:0]      seen, seen_nxt;

    // chg compares the pair being sampled on this edge with the one held now,
    // so the counter restarts on the same edge that loads a new pair.
    assign chg   = {ssd_an, ssd_seg} != {s_an, s_seg};
    assign an_ok = onehot_low(s_an);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_an  <= AN_BLANK;
            s_seg <= SEG_BLANK;
            cnt   <= '0;
        end else begin
            s_an  <= ssd_an;
            s_seg <= ssd_seg;
            if (chg)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!s_an[i]) idx = 2'(i);
    end

    seg_decode u_dec (
        .seg   (s_seg[7:1]),
        .value (dval),
        .hit   (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IGNORE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        if (!an_ok) begin
            state_nxt = ST_IGNORE;
        end else begin
            case (state)
                ST_IGNORE:   state_nxt = ST_SETTLING;
                ST_SETTLING: begin
                    // capture on the edge the counter would reach CNT_MAX
                    if (!chg && cnt == CNT_MAX - 1'b1) begin
                        cap       = 1'b1;
                        state_nxt = ST_HELD;
                    end
                end
                ST_HELD:     if (chg) state_nxt = ST_SETTLING;
                default:     state_nxt = ST_IGNORE;
            endcase
        end
    end

    // Shadow contents with the current capture merged in.
    always_comb begin
        fr_val      = sh_val;
        fr_dp       = sh_dp;
        fr_err      = sh_err;
        fr_val[idx] = dval;
        fr_dp[idx]  = ~s_seg[0];
        fr_err[idx] = ~hit;
        seen_nxt    = seen | (4'b0001 << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_val      <= '0;
            sh_dp       <= '0;
            sh_err      <= '0;
            seen        <= '0;
            digits      <= '0;
            dps         <= '0;
            errs        <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (cap) begin
                sh_val <= fr_val;
                sh_dp  <= fr_dp;
                sh_err <= fr_err;
                if (seen_nxt == 4'hF) begin
                    digits      <= fr_val;
                    dps         <= fr_dp;
                    errs        <= fr_err;
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_reader.sv
// Drives seg_reader with directed scans and random display traffic, checking
// every cycle against a run-length based model of digit capture.
module tb_seg_reader;

    localparam int SC = 4;
    localparam logic [6:0] PATS [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ssd_an;
    logic [7:0]  ssd_seg;
    logic [15:0] digits;
    logic [3:0]  dps, errs;
    logic        frame_valid;

    always #5 clk = ~clk;

    seg_reader #(.STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .ssd_an      (ssd_an),
        .ssd_seg     (ssd_seg),
        .digits      (digits),
        .dps         (dps),
        .errs        (errs),
        .frame_valid (frame_valid)
    );

    int n_chk = 0, n_fail = 0, fv_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: a pair is captured when it has been seen on exactly SC+1
    // consecutive edges and selects a single digit.
    logic [11:0] m_last;
    int          m_run;
    logic [3:0]  m_seen, m_val [4], m_dps, m_errs, m_sdp, m_serr;
    logic [15:0] m_digits;
    logic        m_fv;

    task automatic mdec(input logic [6:0] p, output logic [3:0] v, output logic e);
        v = 4'h0;
        e = 1'b1;
        for (int k = 0; k < 16; k++)
            if (PATS[k] == p) begin
                v = 4'(k);
                e = 1'b0;
            end
    endtask

    task automatic mreset();
        m_last = 12'hFFF; m_run = 0; m_seen = 0; m_sdp = 0; m_serr = 0;
        for (int k = 0; k < 4; k++) m_val[k] = 0;
        m_digits = 0; m_dps = 0; m_errs = 0;
    endtask

    task automatic step(input logic r, input logic [3:0] an, input logic [7:0] sg);
        int n;
        logic [3:0] v;
        logic e;
        rst = r; ssd_an = an; ssd_seg = sg;
        @(posedge clk);
        #1;
        m_fv = 1'b0;
        if (r) begin
            mreset();
        end else begin
            if ({an, sg} == m_last) m_run++;
            else m_run = 1;
            m_last = {an, sg};
            if ($countones(~an) == 1 && m_run == SC + 1) begin
                n = 0;
                for (int k = 0; k < 4; k++) if (!an[k]) n = k;
                mdec(sg[7:1], v, e);
                m_val[n] = v; m_sdp[n] = ~sg[0]; m_serr[n] = e; m_seen[n] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_digits = {m_val[3], m_val[2], m_val[1], m_val[0]};
                    m_dps = m_sdp; m_errs = m_serr; m_fv = 1'b1; m_seen = 0;
                end
            end
        end
        if (frame_valid === 1'b1) fv_cnt++;
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("digits", 32'(digits), 32'(m_digits));
        chk("dps", 32'(dps), 32'(m_dps));
        chk("errs", 32'(errs), 32'(m_errs));
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] sg, input int n);
        repeat (n) step(1'b0, an, sg);
    endtask

    task automatic do_reset();
        repeat (2) step(1'b1, 4'hF, 8'hFF);
        hold(4'hF, 8'hFF, 2);
    endtask

    int f0;
    logic [3:0] ran;
    logic [7:0] rsg;

    initial begin
        rst = 1'b1; ssd_an = 4'hF; ssd_seg = 8'hFF;
        mreset();
        do_reset();
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_fv", 32'(frame_valid), 32'h0);

        // basic scan
        f0 = fv_cnt;
        hold(4'b0111, 8'h25, 6); hold(4'b1011, 8'h0D, 6);
        hold(4'b1101, 8'h99, 6); hold(4'b1110, 8'h49, 6);
        chk("scan_fv_count", 32'(fv_cnt - f0), 32'd1);
        chk("scan_digits", 32'(digits), 32'h2345);
        chk("scan_dps", 32'(dps), 32'h0);
        chk("scan_errs", 32'(errs), 32'h0);

        // short hold of digit 0 must not capture
        do_reset();
        f0 = fv_cnt;
        hold(4'b0111, 8'h25, 6); hold(4'b1011, 8'h0D, 6); hold(4'b1101, 8'h99, 6);
        hold(4'b1110, 8'h1F, 3);
        hold(4'hF, 8'hFF, 2);
        chk("short_no_fv", 32'(fv_cnt - f0), 32'd0);
        hold(4'b1110, 8'h09, 6);
        chk("short_fv_once", 32'(fv_cnt - f0), 32'd1);
        chk("short_digits", 32'(digits), 32'h2349);

        // unrecognised pattern with dp lit
        do_reset();
        hold(4'b0111, 8'h25, 6); hold(4'b1011, 8'hFE, 6);
        hold(4'b1101, 8'h99, 6); hold(4'b1110, 8'h49, 6);
        chk("err_errs", 32'(errs), 32'h4);
        chk("err_dps", 32'(dps), 32'h4);
        chk("err_nib", 32'(digits[11:8]), 32'h0);

        // two digits enabled: ignored, seen untouched
        do_reset();
        f0 = fv_cnt;
        hold(4'b0111, 8'h03, 6); hold(4'b1011, 8'h25, 6); hold(4'b1101, 8'h0D, 6);
        hold(4'b1100, 8'h25, 20);
        chk("multi_no_fv", 32'(fv_cnt - f0), 32'd0);
        hold(4'b1110, 8'h99, 6);
        chk("multi_fv", 32'(fv_cnt - f0), 32'd1);
        chk("multi_digits", 32'(digits), 32'h0234);

        // recapture overwrites
        do_reset();
        hold(4'b1101, 8'h9F, 6); hold(4'b0111, 8'h25, 6);
        hold(4'b1101, 8'h0D, 6); hold(4'b1011, 8'h25, 6); hold(4'b1110, 8'h49, 6);
        chk("recap_nib", 32'(digits[7:4]), 32'h3);

        // reset mid-frame
        do_reset();
        hold(4'b0111, 8'h25, 6); hold(4'b1011, 8'h0D, 6); hold(4'b1101, 8'h99, 6);
        f0 = fv_cnt;
        repeat (2) step(1'b1, 4'b1101, 8'h99);
        hold(4'b1110, 8'h49, 6);
        chk("rst_no_fv", 32'(fv_cnt - f0), 32'd0);
        chk("rst_digits0", 32'(digits), 32'h0);
        hold(4'b0111, 8'h25, 6); hold(4'b1011, 8'h0D, 6);
        chk("rst_still0", 32'(digits), 32'h0);
        hold(4'b1101, 8'h99, 6);
        chk("rst_fv", 32'(fv_cnt - f0), 32'd1);
        chk("rst_digits", 32'(digits), 32'h2345);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 85) begin
                ran = 4'b0001 << $urandom_range(0, 3);
                ran = ~ran;
            end else begin
                ran = 4'($urandom);
            end
            if ($urandom_range(0, 99) < 80)
                rsg = {PATS[$urandom_range(0, 15)], 1'($urandom)};
            else
                rsg = 8'($urandom);
            if ($urandom_range(0, 99) < 2)
                step(1'b1, ran, rsg);
            else
                hold(ran, rsg, int'($urandom_range(1, 8)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples required before a digit is captured; legal range 2..255.
REQ-002 Clock and reset are fixed: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ssd_an  in  4  digit enables, active-low; bit n selects digit n (digit 0 rightmost).
REQ-006 ssd_seg  in  8  segment lines, active-low; bit7..bit1 = segments a..g, bit0 = dp.
REQ-007 digits  out  16  last complete frame; nibble n = value of digit n.
REQ-008 dps  out  4  last complete frame; bit n = 1 when digit n's dp is lit.
REQ-009 errs  out  4  last complete frame; bit n = 1 when digit n's pattern was unrecognised.
REQ-010 frame_valid  out  1  one-cycle pulse when digits/dps/errs update.

Function
REQ-011 ssd_an and ssd_seg SHALL be registered once, giving the sample pair s_an/s_seg; all logic below uses the sample pair.
REQ-012 Decode SHALL map seg[7:1] (dp ignored) to a nibble: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F.
REQ-013 Any other seg[7:1] SHALL decode to nibble 0 with error flag set.
REQ-014 dp SHALL be reported lit when s_seg[0] = 0.
REQ-015 A stability counter SHALL clear to 0 whenever {s_an,s_seg} differs from its previous-cycle value, otherwise increment, saturating at STABLE_CYCLES.
REQ-016 The FSM SHALL have states IGNORE, SETTLING and HELD.
REQ-017 Any cycle in which s_an is not one-hot-low SHALL force IGNORE. This covers all-ones blanking and multiple enabled digits. In IGNORE, no capture occurs.
REQ-018 IGNORE -> SETTLING SHALL occur when s_an becomes one-hot-low.
REQ-019 SETTLING -> HELD SHALL occur, with exactly one capture, on the edge where the counter reaches STABLE_CYCLES.
REQ-020 HELD -> SETTLING SHALL occur on any change of the sample pair to another one-hot-low value.
REQ-021 While in HELD, no further capture SHALL occur, however long the pair is held.
REQ-022 A capture SHALL write the decoded nibble, dp and error flag into shadow slot n, where n is the enabled digit, and SHALL set seen[n].
REQ-023 A repeated capture of the same digit within a frame SHALL overwrite shadow slot n; the latest capture wins.
REQ-024 On the edge where seen becomes 4'b1111, the block SHALL do all of the following together:
- copy all shadow slots, including the capture made on that same edge, to digits/dps/errs;
- pulse frame_valid for that one cycle;
- clear seen to 0.
REQ-025 Outputs SHALL hold their values between frames.
REQ-026 Latency: a pair held steady from the edge at which it is first sampled (edge 1) SHALL be captured on edge STABLE_CYCLES+1. With the default, capture is on edge 5.
REQ-027 Any change of the pair before capture SHALL restart settling; that glitch is never captured.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL reset to:
- digits = 16'h0000, dps = 0, errs = 0, frame_valid = 0;
- seen = 0, shadow slots = 0, counter = 0;
- FSM = IGNORE, sample pair = {4'hF, 8'hFF}.
REQ-029 Reset mid-frame SHALL discard partial captures; the first frame_valid after reset requires four fresh captures.

Structure
REQ-030 The 16 segment-pattern constants and the FSM state encoding SHALL live in shared package seg_pkg, alongside the display-side pattern definitions.
REQ-031 Pattern-to-nibble decoding SHALL be a combinational sub-module seg_decode: input seg[7:1]; outputs value[3:0] and hit.
REQ-032 All other logic SHALL be in seg_reader.

Verification
REQ-033 Scan digits 3..0 with patterns 0x25, 0x0D, 0x99, 0x49 (dp off), each held 6 cycles -> one frame_valid pulse; digits = 16'h2345, dps = 0, errs = 0.
REQ-034 Digit 0 held only 3 cycles, then an = 4'b1111 for 2 cycles, then held 6 cycles -> exactly one capture of digit 0; no capture from the 3-cycle hold.
REQ-035 Digit 2 driven with seg = 8'hFE (only dp lit) in a full scan -> errs = 4'b0100, dps = 4'b0100, digits[11:8] = 0.
REQ-036 ssd_an = 4'b1100 held 20 cycles -> no capture, no frame_valid, seen unchanged.
REQ-037 Digit 1 captured as 0x9F (value 1), then recaptured as 0x0D (value 3) before the frame completes -> digits[7:4] = 3.
REQ-038 rst asserted after 3 of 4 captures, then one further capture -> no frame_valid. A full scan after that -> frame_valid; all outputs were 0 until then.
